// File: rtl/bit_stepper.sv
// bit_stepper: conditions a raw push button and data switch into a clean,
// strobed bit stream for the serial-pattern detector. Manual mode issues one
// bit per debounced press; auto mode replays a pattern MSB first at a fixed
// rate. Every issued bit is qualified by a one-cycle step strobe.
module bit_stepper #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int AUTO_DIV   = 50_000_000,
  parameter int PAT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             btn,
  input  logic             sw_x,
  input  logic             auto,
  input  logic [PAT_W-1:0] pattern,
  output logic             x,
  output logic             step,
  output logic [7:0]       bit_cnt
);

  localparam int DCW  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int DIVW = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
  localparam int IW   = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic [DCW-1:0]  DCNT_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(AUTO_DIV - 1);
  localparam logic [IW-1:0]   IDX_TOP   = IW'(PAT_W - 1);

  // The mode register doubles as "previous auto_s"; a mismatch with the
  // synchronized switch marks a mode-change cycle.
  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  // synchronizer stages
  logic btn_m_r, sw_m_r, auto_m_r;
  logic btn_s, sw_s, auto_s;

  // debouncer and press detect
  logic           btn_d;
  logic [DCW-1:0] dcnt;
  logic           btn_q_r;
  logic           press;

  // mode FSM and auto-mode sequencing
  mode_t           state_r, state_nxt;
  logic [DIVW-1:0] div, div_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            mode_chg_s;
  logic            man_fire_s, auto_fire_s;
  logic            step_nxt, x_nxt;

  // Two-flop synchronizers for the three asynchronous inputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_m_r  <= 1'b0;
      btn_s    <= 1'b0;
      sw_m_r   <= 1'b0;
      sw_s     <= 1'b0;
      auto_m_r <= 1'b0;
      auto_s   <= 1'b0;
    end else begin
      btn_m_r  <= btn;
      btn_s    <= btn_m_r;
      sw_m_r   <= sw_x;
      sw_s     <= sw_m_r;
      auto_m_r <= auto;
      auto_s   <= auto_m_r;
    end
  end

  // Debouncer: accept a new button level only after DEB_CYCLES consecutive
  // differing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_d <= 1'b0;
      dcnt  <= {DCW{1'b0}};
    end else if (btn_s != btn_d) begin
      if (dcnt == DCNT_LAST) begin
        btn_d <= ~btn_d;
        dcnt  <= {DCW{1'b0}};
      end else begin
        dcnt  <= dcnt + DCW'(1);
      end
    end else begin
      dcnt <= {DCW{1'b0}};
    end
  end

  // Registered rising-edge detect on the debounced level; releases are ignored.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_q_r <= 1'b0;
      press   <= 1'b0;
    end else begin
      btn_q_r <= btn_d;
      press   <= btn_d & ~btn_q_r;
    end
  end

  // Mode FSM state plus divider and pattern index registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= MANUAL;
      div     <= {DIVW{1'b0}};
      idx     <= IDX_TOP;
    end else begin
      state_r <= state_nxt;
      div     <= div_nxt;
      idx     <= idx_nxt;
    end
  end

  // Next-state and bit-issue decision; a mode-change cycle clears the
  // sequencer and suppresses both auto emission and manual presses.
  always_comb begin
    state_nxt   = MANUAL;
    div_nxt     = div;
    idx_nxt     = idx;
    man_fire_s  = 1'b0;
    auto_fire_s = 1'b0;
    x_nxt       = x;

    if (auto_s) begin
      state_nxt = AUTO;
    end else begin
      state_nxt = MANUAL;
    end

    mode_chg_s = (state_nxt != state_r);

    if (mode_chg_s) begin
      div_nxt = {DIVW{1'b0}};
      idx_nxt = IDX_TOP;
    end else begin
      case (state_r)
        MANUAL: begin
          div_nxt = {DIVW{1'b0}};
          if (press) begin
            man_fire_s = 1'b1;
            x_nxt      = sw_s;
          end else begin
            man_fire_s = 1'b0;
          end
        end
        AUTO: begin
          if (div == DIV_LAST) begin
            div_nxt     = {DIVW{1'b0}};
            auto_fire_s = 1'b1;
            x_nxt       = pattern[idx];
            if (idx == {IW{1'b0}}) begin
              idx_nxt = IDX_TOP;
            end else begin
              idx_nxt = idx - IW'(1);
            end
          end else begin
            div_nxt = div + DIVW'(1);
          end
        end
        default: begin
          div_nxt = {DIVW{1'b0}};
          idx_nxt = IDX_TOP;
        end
      endcase
    end

    step_nxt = man_fire_s | auto_fire_s;
  end

  // Registered outputs: issued bit, strobe and running bit count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      x       <= 1'b0;
      step    <= 1'b0;
      bit_cnt <= 8'd0;
    end else begin
      x    <= x_nxt;
      step <= step_nxt;
      if (step_nxt) begin
        bit_cnt <= bit_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bit_stepper.sv
// Self-checking bench for bit_stepper with small parameters. A reference
// model describes behaviour as events: accepted presses become scheduled
// step times, and auto-mode steps are computed arithmetically from the
// cycle the mode last changed.
module tb_bit_stepper;

  localparam int DEB  = 4;
  localparam int ADIV = 3;
  localparam int PW   = 8;

  logic          clk;
  logic          rstn;
  logic          btn;
  logic          sw_x;
  logic          auto;
  logic [PW-1:0] pattern;
  logic          x;
  logic          step;
  logic [7:0]    bit_cnt;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int steps_seen = 0;

  // reference model state
  bit   bq0, bq1, sq0, sq1, aq0, aq1;
  bit   m_lvl;
  int   m_run;
  int   due[$];
  bit   m_prev_auto;
  int   t0;
  bit   m_x, m_step;
  logic [7:0] m_cnt;

  bit_stepper #(.DEB_CYCLES(DEB), .AUTO_DIV(ADIV), .PAT_W(PW)) dut (
    .clk(clk), .rstn(rstn), .btn(btn), .sw_x(sw_x), .auto(auto),
    .pattern(pattern), .x(x), .step(step), .bit_cnt(bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Model of one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit bs, ss, as_;
    bit press_now, emit, val;
    int k;
    if (!rstn) begin
      bq0 = 0; bq1 = 0; sq0 = 0; sq1 = 0; aq0 = 0; aq1 = 0;
      m_lvl = 0; m_run = 0; due.delete();
      m_prev_auto = 0; t0 = n;
      m_x = 0; m_step = 0; m_cnt = 8'd0;
      return;
    end
    bs = bq1; ss = sq1; as_ = aq1;
    bq1 = bq0; bq0 = btn;
    sq1 = sq0; sq0 = sw_x;
    aq1 = aq0; aq0 = auto;
    press_now = 0;
    while (due.size() > 0 && due[0] <= n) begin
      if (due[0] == n) press_now = 1;
      void'(due.pop_front());
    end
    // a level is accepted after DEB consecutive differing samples;
    // an accepted rise reaches the output two edges later
    if (bs != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl = bs;
        m_run = 0;
        if (bs) due.push_back(n + 2);
      end
    end else begin
      m_run = 0;
    end
    emit = 0; val = 0;
    if (as_ != m_prev_auto) begin
      t0 = n;
    end else if (as_) begin
      if (n > t0 && ((n - t0) % ADIV) == 0) begin
        k = (n - t0) / ADIV - 1;
        emit = 1;
        val = pattern[PW - 1 - (k % PW)];
      end
    end else if (press_now) begin
      emit = 1;
      val = ss;
    end
    m_prev_auto = as_;
    if (emit) begin
      m_x = val;
      m_cnt = m_cnt + 8'd1;
    end
    m_step = emit;
  endtask

  // One clock: advance the model at the edge, compare outputs mid-cycle.
  task automatic tick();
    @(posedge clk);
    n++;
    model_edge();
    @(negedge clk);
    chk("x", {7'd0, x}, {7'd0, m_x});
    chk("step", {7'd0, step}, {7'd0, m_step});
    chk("bit_cnt", bit_cnt, m_cnt);
    if (step === 1'b1) steps_seen++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int c;
    int k;
    int got_n;
    int last_t;
    bit saw255;
    logic [8:0] exp_seq;

    rstn = 1'b0; btn = 1'b1; auto = 1'b1; sw_x = 1'b0; pattern = 8'h00;

    // reset held with button and auto asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_x", {7'd0, x}, 8'd0);
      chk("rst_step", {7'd0, step}, 8'd0);
      chk("rst_cnt", bit_cnt, 8'd0);
    end
    rstn = 1'b1;
    pattern = 8'hFF;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      tick();
      if (step === 1'b1) k = i;
    end
    chk("rst_first_late", {7'd0, (k >= 5)}, 8'd1);

    // manual clean press
    btn = 1'b0; auto = 1'b0;
    do_reset();
    repeat (4) tick();
    sw_x = 1'b1; btn = 1'b1;
    c = steps_seen;
    repeat (7) tick();
    chk("man_early", 8'(steps_seen - c), 8'd0);
    tick();
    chk("man_step", {7'd0, step}, 8'd1);
    chk("man_x", {7'd0, x}, 8'd1);
    chk("man_cnt", bit_cnt, 8'd1);
    sw_x = 1'b0;
    repeat (5) tick();
    chk("man_x_hold", {7'd0, x}, 8'd1);
    btn = 1'b0;
    repeat (12) tick();
    chk("man_release", 8'(steps_seen - c), 8'd1);

    // bounce then hold
    c = steps_seen;
    btn = 1'b1; tick(); btn = 1'b0; tick();
    btn = 1'b1; tick(); btn = 1'b0; tick();
    btn = 1'b1;
    repeat (7) tick();
    chk("bounce_early", 8'(steps_seen - c), 8'd0);
    tick();
    chk("bounce_step", {7'd0, step}, 8'd1);
    chk("bounce_x", {7'd0, x}, 8'd0);
    repeat (5) tick();
    btn = 1'b0;
    repeat (12) tick();
    chk("bounce_once", 8'(steps_seen - c), 8'd1);

    // short glitches are discarded
    c = steps_seen;
    repeat (2) begin
      btn = 1'b1; repeat (3) tick();
      btn = 1'b0; repeat (10) tick();
    end
    chk("glitch", 8'(steps_seen - c), 8'd0);

    // auto pattern replay
    do_reset();
    pattern = 8'b1011_0001; auto = 1'b1;
    exp_seq = 9'b1_0110_0011;
    got_n = 0; last_t = 0;
    for (int i = 0; i < 80 && got_n < 9; i++) begin
      tick();
      if (step === 1'b1) begin
        chk("auto_x", {7'd0, x}, {7'd0, exp_seq[8 - got_n]});
        if (got_n > 0) chk("auto_gap", 8'(n - last_t), 8'd3);
        last_t = n;
        got_n++;
      end
    end
    chk("auto_steps", 8'(got_n), 8'd9);
    chk("auto_cnt", bit_cnt, 8'd9);

    // mode switch mid-pattern restarts the index
    auto = 1'b0;
    do_reset();
    pattern = 8'h8F; auto = 1'b1;
    got_n = 0;
    for (int i = 0; i < 40 && got_n < 3; i++) begin
      tick();
      if (step === 1'b1) got_n++;
    end
    chk("sw_pre_steps", 8'(got_n), 8'd3);
    auto = 1'b0; tick(); tick();
    auto = 1'b1;
    got_n = 0;
    for (int i = 0; i < 40 && got_n < 2; i++) begin
      tick();
      if (step === 1'b1) begin
        chk(got_n == 0 ? "sw_restart_x" : "sw_second_x", {7'd0, x},
            got_n == 0 ? 8'd1 : 8'd0);
        got_n++;
      end
    end
    chk("sw_post_steps", 8'(got_n), 8'd2);
    // press while in auto: spacing must stay exactly AUTO_DIV
    btn = 1'b1; sw_x = 1'b1;
    last_t = -1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) btn = 1'b0;
      tick();
      if (step === 1'b1) begin
        if (last_t >= 0) chk("auto_press_gap", 8'(n - last_t), 8'd3);
        last_t = n;
      end
    end

    // 256 manual presses wrap the counter
    auto = 1'b0; btn = 1'b0;
    do_reset();
    repeat (4) tick();
    c = steps_seen;
    saw255 = 0;
    for (int p = 0; p < 256; p++) begin
      sw_x = p[0];
      btn = 1'b1; repeat (6) tick();
      if (bit_cnt === 8'd255) saw255 = 1;
      btn = 1'b0; repeat (6) tick();
    end
    repeat (4) tick();
    chk("wrap_steps", 8'(steps_seen - c), 8'd0);
    chk("wrap_steps_lo", {7'd0, ((steps_seen - c) == 256)}, 8'd1);
    chk("wrap_saw255", {7'd0, saw255}, 8'd1);
    chk("wrap_cnt", bit_cnt, 8'd0);

    // randomized run against the model
    for (int i = 0; i < 2500; i++) begin
      rstn = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 4) == 0) btn = ~btn;
      if ($urandom_range(0, 2) == 0) sw_x = $urandom_range(0, 1);
      if ($urandom_range(0, 149) == 0) auto = ~auto;
      if ($urandom_range(0, 39) == 0) pattern = 8'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
